mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 23 ++
 rtl/mem_access_stage_if.sv | 26 ++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/mem_access_stage.sv | 135 +++++++++++++
 tb/tb_mem_access_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: datapath width, control-bit
// positions within the EX/MEM control bundles, and the access FSM encoding.
package mem_access_stage_pkg;

  localparam int INTERNAL_BITS_DEF = 32;

  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int WIDTH = INTERNAL_BITS_DEF
);

  logic             dmem_req;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles spent waiting for a memory acknowledge; expired flags
// the last cycle the stage is willing to wait.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Holds at the limit so a stray enable after expiry cannot wrap around.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls the front of the
// pipeline while waiting, and produces the registered MEM/WB bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int INTERNAL_BITS = INTERNAL_BITS_DEF,
  parameter int WAIT_LIMIT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               WB_in,
  input  logic [2:0]               M_in,
  input  logic [INTERNAL_BITS-1:0] ALU_result_in,
  input  logic [INTERNAL_BITS-1:0] ALU_src2_in,
  input  logic                     ALU_zero_in,
  input  logic [INTERNAL_BITS-1:0] PC_in,
  input  logic [4:0]               REG_dst_in,
  mem_access_stage_if.master       dmem,
  output logic                     stall_out,
  output logic                     PCSrc_out,
  output logic [INTERNAL_BITS-1:0] PC_branch_out,
  output logic [1:0]               WB_out,
  output logic [INTERNAL_BITS-1:0] mem_data_out,
  output logic [INTERNAL_BITS-1:0] ALU_result_out,
  output logic [4:0]               REG_dst_out,
  output logic                     fault_out
);

  mem_state_e               state;
  logic [INTERNAL_BITS-1:0] addr_q;
  logic [INTERNAL_BITS-1:0] wdata_q;
  logic                     we_q;
  logic [1:0]               wb_q;
  logic [4:0]               reg_dst_q;

  logic mem_op;
  logic illegal;
  logic legal_mem;
  logic in_access;
  logic timer_expired;
  logic abort;

  assign mem_op    = M_in[M_MEM_READ] ^ M_in[M_MEM_WRITE];
  assign illegal   = (M_in[M_MEM_READ] & M_in[M_MEM_WRITE]) |
                     (mem_op & is_misaligned(ALU_result_in[1:0]));
  assign legal_mem = mem_op & ~illegal;
  assign in_access = (state == ST_ACCESS);

  // An acknowledge in the final wait cycle still counts as a completion.
  assign abort = in_access & ~dmem.dmem_ack & timer_expired;

  mem_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (~in_access & legal_mem),
    .enable  (in_access & ~dmem.dmem_ack),
    .expired (timer_expired)
  );

  assign stall_out = ~rst & ((~in_access & legal_mem) |
                             (in_access & ~dmem.dmem_ack & ~abort));

  assign PCSrc_out     = ~in_access & M_in[M_BRANCH] & ALU_zero_in;
  assign PC_branch_out = in_access ? '0 : PC_in;

  assign dmem.dmem_req   = in_access;
  assign dmem.dmem_we    = in_access & we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  // Stalled cycles push a bubble (WB_out = 0) into MEM/WB; data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      wb_q           <= '0;
      reg_dst_q      <= '0;
      WB_out         <= '0;
      mem_data_out   <= '0;
      ALU_result_out <= '0;
      REG_dst_out    <= '0;
      fault_out      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (illegal) begin
            WB_out    <= '0;
            fault_out <= 1'b1;
          end else if (legal_mem) begin
            addr_q    <= ALU_result_in;
            wdata_q   <= ALU_src2_in;
            we_q      <= M_in[M_MEM_WRITE];
            wb_q      <= WB_in;
            reg_dst_q <= REG_dst_in;
            WB_out    <= '0;
            fault_out <= 1'b0;
            state     <= ST_ACCESS;
          end else begin
            WB_out         <= WB_in;
            ALU_result_out <= ALU_result_in;
            REG_dst_out    <= REG_dst_in;
            fault_out      <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (dmem.dmem_ack) begin
            WB_out         <= wb_q;
            ALU_result_out <= addr_q;
            REG_dst_out    <= reg_dst_q;
            if (!we_q) begin
              mem_data_out <= dmem.dmem_rdata;
            end
            fault_out      <= 1'b0;
            state          <= ST_IDLE;
          end else if (abort) begin
            WB_out    <= '0;
            fault_out <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            WB_out    <= '0;
            fault_out <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage against a transaction-level
// model of the MEM/WB bundle and the request/stall timing.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int W  = 32;
  localparam int WL = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    WB_in;
  logic [2:0]    M_in;
  logic [W-1:0]  ALU_result_in;
  logic [W-1:0]  ALU_src2_in;
  logic          ALU_zero_in;
  logic [W-1:0]  PC_in;
  logic [4:0]    REG_dst_in;
  logic          stall_out;
  logic          PCSrc_out;
  logic [W-1:0]  PC_branch_out;
  logic [1:0]    WB_out;
  logic [W-1:0]  mem_data_out;
  logic [W-1:0]  ALU_result_out;
  logic [4:0]    REG_dst_out;
  logic          fault_out;

  int checks = 0;
  int passes = 0;

  logic [1:0]   exp_wb;
  logic         exp_fault;
  logic [4:0]   exp_rd;
  logic [W-1:0] exp_alu;
  logic [W-1:0] exp_mem;

  always #5 clk = ~clk;

  mem_access_stage_if #(.WIDTH(W)) dmem ();

  mem_access_stage #(
    .INTERNAL_BITS (W),
    .WAIT_LIMIT    (WL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .WB_in          (WB_in),
    .M_in           (M_in),
    .ALU_result_in  (ALU_result_in),
    .ALU_src2_in    (ALU_src2_in),
    .ALU_zero_in    (ALU_zero_in),
    .PC_in          (PC_in),
    .REG_dst_in     (REG_dst_in),
    .dmem           (dmem),
    .stall_out      (stall_out),
    .PCSrc_out      (PCSrc_out),
    .PC_branch_out  (PC_branch_out),
    .WB_out         (WB_out),
    .mem_data_out   (mem_data_out),
    .ALU_result_out (ALU_result_out),
    .REG_dst_out    (REG_dst_out),
    .fault_out      (fault_out)
  );

  function automatic logic [71:0] exp_memwb();
    return {exp_wb, exp_fault, exp_rd, exp_alu, exp_mem};
  endfunction

  function automatic logic [71:0] act_memwb();
    return {WB_out, fault_out, REG_dst_out, ALU_result_out, mem_data_out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] wb, input logic [2:0] m, input logic [W-1:0] alu,
                          input logic [W-1:0] src2, input logic [W-1:0] pc, input logic z,
                          input logic [4:0] rd);
    WB_in         = wb;
    M_in          = m;
    ALU_result_in = alu;
    ALU_src2_in   = src2;
    PC_in         = pc;
    ALU_zero_in   = z;
    REG_dst_in    = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_op(2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    step();
    step();
    rst = 1'b0;
    drive_op(2'b11, 3'b000, 32'hABCD_0000, '0, '0, 1'b0, 5'd9);
    step();
    checks++;
    if (act_memwb() !== {2'b11, 1'b0, 5'd9, 32'hABCD_0000, 32'h0})
      $display("[TB] FAIL reset_preload: got %h expected %h", act_memwb(),
               {2'b11, 1'b0, 5'd9, 32'hABCD_0000, 32'h0});
    else passes++;
    rst = 1'b1;
    drive_op(2'b11, 3'b010, 32'h40, 32'h5, 32'h8, 1'b1, 5'd3);
    step();
    rst = 1'b0;
    drive_op(2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0);
    #3;
    checks++;
    if (act_memwb() !== 72'h0)
      $display("[TB] FAIL reset_memwb: got %h expected %h", act_memwb(), 72'h0);
    else passes++;
    checks++;
    if (dmem.dmem_req !== 1'b0 || stall_out !== 1'b0)
      $display("[TB] FAIL reset_req_stall: got req=%b stall=%b expected 0 0", dmem.dmem_req, stall_out);
    else passes++;
    exp_wb = '0; exp_fault = 1'b0; exp_rd = '0; exp_alu = '0; exp_mem = '0;
    step();
  endtask

  task automatic test_alu_op();
    logic [1:0] wb; logic [2:0] m; logic [W-1:0] alu, pc; logic z; logic [4:0] rd;
    for (int i = 0; i < 24; i++) begin
      wb  = 2'($urandom());
      m   = {1'($urandom()), 2'b00};
      alu = $urandom();
      pc  = $urandom();
      z   = 1'($urandom());
      rd  = 5'($urandom());
      if (i == 0) begin
        wb = 2'b10; m = 3'b000; alu = 32'h0000_0044;
      end
      drive_op(wb, m, alu, $urandom(), pc, z, rd);
      dmem.dmem_ack   = 1'($urandom());
      dmem.dmem_rdata = $urandom();
      #3;
      checks++;
      if (stall_out !== 1'b0 || dmem.dmem_req !== 1'b0)
        $display("[TB] FAIL alu_stall_req[%0d]: got stall=%b req=%b expected 0 0", i, stall_out, dmem.dmem_req);
      else passes++;
      checks++;
      if ({PCSrc_out, PC_branch_out} !== {m[M_BRANCH] & z, pc})
        $display("[TB] FAIL alu_branch[%0d]: got %b/%h expected %b/%h", i, PCSrc_out, PC_branch_out,
                 m[M_BRANCH] & z, pc);
      else passes++;
      step();
      exp_wb = wb; exp_alu = alu; exp_rd = rd; exp_fault = 1'b0;
      checks++;
      if (act_memwb() !== exp_memwb())
        $display("[TB] FAIL alu_memwb[%0d]: got %h expected %h", i, act_memwb(), exp_memwb());
      else passes++;
    end
    dmem.dmem_ack = 1'b0;
  endtask

  task automatic test_mem_ops();
    logic store, br, z; logic [W-1:0] addr, data, pc, nop_alu; logic [1:0] wb, nop_wb;
    logic [4:0] rd, nop_rd; int k, end_c;
    for (int i = 0; i < 16; i++) begin
      store = 1'($urandom());
      addr  = $urandom();
      addr[1:0] = 2'b00;
      data  = $urandom();
      pc    = $urandom();
      wb    = 2'($urandom());
      rd    = 5'($urandom());
      br    = 1'($urandom());
      z     = 1'($urandom());
      k     = $urandom_range(1, WL + 3);
      case (i)
        0: begin
          store = 1'b0; addr = 32'h100; data = 32'hDEAD_BEEF; k = 3;
          wb = '0; wb[WB_REG_WRITE] = 1'b1; wb[WB_MEM_TO_REG] = 1'b1;
        end
        1: begin store = 1'b1; addr = 32'h200; data = 32'h1234_5678; k = 1; end
        2: begin store = 1'b0; k = WL + 1; end
        3: begin store = 1'b0; k = WL; end
        4: begin store = 1'b0; k = 1; end
        default: ;
      endcase
      end_c = (k <= WL) ? k : WL;
      drive_op(wb, {br, ~store, store}, addr, data, pc, z, rd);
      for (int c = 0; c <= end_c; c++) begin
        dmem.dmem_ack   = (c == k);
        dmem.dmem_rdata = (c == k && !store) ? data : $urandom();
        if (c >= 1) begin
          exp_wb = '0; exp_fault = 1'b0;
        end
        #3;
        checks++;
        if (act_memwb() !== exp_memwb())
          $display("[TB] FAIL mem_memwb[%0d.%0d]: got %h expected %h", i, c, act_memwb(), exp_memwb());
        else passes++;
        checks++;
        if ({stall_out, dmem.dmem_req} !== {c < end_c, c >= 1})
          $display("[TB] FAIL mem_stall_req[%0d.%0d]: got %b%b expected %b%b", i, c, stall_out,
                   dmem.dmem_req, c < end_c, c >= 1);
        else passes++;
        checks++;
        if ({PCSrc_out, PC_branch_out} !== ((c == 0) ? {br & z, pc} : 33'h0))
          $display("[TB] FAIL mem_branch[%0d.%0d]: got %b/%h expected %h", i, c, PCSrc_out,
                   PC_branch_out, (c == 0) ? {br & z, pc} : 33'h0);
        else passes++;
        if (c >= 1) begin
          checks++;
          if ({dmem.dmem_we, dmem.dmem_addr} !== {store, addr})
            $display("[TB] FAIL mem_bus[%0d.%0d]: got we=%b addr=%h expected we=%b addr=%h", i, c,
                     dmem.dmem_we, dmem.dmem_addr, store, addr);
          else passes++;
          if (store) begin
            checks++;
            if (dmem.dmem_wdata !== data)
              $display("[TB] FAIL mem_wdata[%0d.%0d]: got %h expected %h", i, c, dmem.dmem_wdata, data);
            else passes++;
          end
        end
        step();
      end
      if (k <= WL) begin
        exp_wb = wb; exp_alu = addr; exp_rd = rd; exp_fault = 1'b0;
        if (!store) exp_mem = data;
      end else begin
        exp_wb = '0; exp_fault = 1'b1;
      end
      nop_wb  = 2'($urandom());
      nop_alu = $urandom();
      nop_rd  = 5'($urandom());
      drive_op(nop_wb, 3'b000, nop_alu, $urandom(), $urandom(), 1'b0, nop_rd);
      dmem.dmem_ack   = (k == end_c + 1);
      dmem.dmem_rdata = $urandom();
      #3;
      checks++;
      if (act_memwb() !== exp_memwb())
        $display("[TB] FAIL mem_done[%0d]: got %h expected %h", i, act_memwb(), exp_memwb());
      else passes++;
      checks++;
      if ({stall_out, dmem.dmem_req} !== 2'b00)
        $display("[TB] FAIL mem_release[%0d]: got stall=%b req=%b expected 0 0", i, stall_out, dmem.dmem_req);
      else passes++;
      step();
      dmem.dmem_ack = 1'b0;
      exp_wb = nop_wb; exp_alu = nop_alu; exp_rd = nop_rd; exp_fault = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [2:0] m; logic [W-1:0] alu; int kind;
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      alu  = $urandom();
      m    = {1'($urandom()), 2'b11};
      if (kind != 0) begin
        alu[1:0] = 2'($urandom_range(1, 3));
        m[1:0]   = (kind == 1) ? 2'b10 : 2'b01;
      end
      if (i == 0) begin m = 3'b010; alu = 32'h102; end
      if (i == 1) m = 3'b011;
      drive_op(2'b11, m, alu, $urandom(), $urandom(), 1'b0, 5'($urandom()));
      #3;
      checks++;
      if ({stall_out, dmem.dmem_req} !== 2'b00)
        $display("[TB] FAIL illegal_issue[%0d]: got stall=%b req=%b expected 0 0", i, stall_out, dmem.dmem_req);
      else passes++;
      step();
      exp_wb = '0; exp_fault = 1'b1;
      checks++;
      if (act_memwb() !== exp_memwb() || dmem.dmem_req !== 1'b0)
        $display("[TB] FAIL illegal_fault[%0d]: got %h req=%b expected %h req=0", i, act_memwb(),
                 dmem.dmem_req, exp_memwb());
      else passes++;
    end
    drive_op(2'b01, 3'b000, 32'h77, '0, '0, 1'b0, 5'd4);
    step();
    exp_wb = 2'b01; exp_alu = 32'h77; exp_rd = 5'd4; exp_fault = 1'b0;
    checks++;
    if (act_memwb() !== exp_memwb())
      $display("[TB] FAIL illegal_clear: got %h expected %h", act_memwb(), exp_memwb());
    else passes++;
  endtask

  task automatic test_reset_in_access();
    drive_op(2'b11, 3'b010, 32'h300, '0, '0, 1'b0, 5'd7);
    step();
    #3;
    checks++;
    if (dmem.dmem_req !== 1'b1)
      $display("[TB] FAIL rstacc_req_before: got %b expected 1", dmem.dmem_req);
    else passes++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_op(2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hCAFE_F00D;
    #3;
    checks++;
    if ({dmem.dmem_req, stall_out} !== 2'b00 || act_memwb() !== 72'h0)
      $display("[TB] FAIL rstacc_after: got req=%b stall=%b memwb=%h expected all 0", dmem.dmem_req,
               stall_out, act_memwb());
    else passes++;
    step();
    dmem.dmem_ack = 1'b0;
    checks++;
    if (act_memwb() !== 72'h0)
      $display("[TB] FAIL rstacc_late_ack: got %h expected %h", act_memwb(), 72'h0);
    else passes++;
    exp_wb = '0; exp_fault = 1'b0; exp_rd = '0; exp_alu = '0; exp_mem = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_op();
    test_mem_ops();
    test_illegal();
    test_reset_in_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
